// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/halt controller for the 5-stage pipeline: load-use and
// branch hazards, multi-cycle memory waits with timeout, HLT drain and halt.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_s_reg,
  input  logic [4:0]       ID_t_reg,
  input  logic             ID_use_s,
  input  logic             ID_use_t,
  input  logic             ID_hlt,
  input  logic [4:0]       EX_dst_reg,
  input  logic             EX_use_dst_reg,
  input  logic             EX_mem_re,
  input  logic             EX_branch_taken,
  input  logic             MEM_mem_access,
  input  logic             mem_rdy,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_flush,
  output logic             hlt,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 2);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALT} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic load_use, mem_stall;

  assign load_use = EX_mem_re && EX_use_dst_reg && (EX_dst_reg != 5'd0) &&
                    ((ID_use_s && (ID_s_reg == EX_dst_reg)) ||
                     (ID_use_t && (ID_t_reg == EX_dst_reg)));
  assign mem_stall = MEM_mem_access && !mem_rdy;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    mem_err_d    = mem_err_q;
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    hlt          = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush} = '1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (EX_branch_taken) begin
          // Squashes anything younger, including a load-use or HLT in ID.
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (load_use) begin
          {pc_stall, IF_ID_stall, ID_EX_flush} = '1;
        end else if (ID_hlt) begin
          {pc_stall, IF_ID_stall, ID_EX_flush} = '1;
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_rdy) begin
          {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush} = '1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
            mem_err_d = 1'b1;
            state_d   = HALT;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush} = '1;
        end else begin
          {pc_stall, IF_ID_stall, ID_EX_flush} = '1;
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
          if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = HALT;
        end
      end
      HALT: begin
        {hlt, pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall} = '1;
      end
      default: state_d = RUN;
    endcase
    // Reset forces every control low in the same cycle it is asserted.
    if (rst) begin
      {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush} = '0;
      {EX_MEM_stall, MEM_WB_flush, hlt} = '0;
    end
    stall_cnt_d = (pc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                    : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q && !rst;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a behavioural
// model tracking "waiting / draining / halted" as plain counters and flags.
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT  = 16;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 8;
  localparam int CMAX         = (1 << CNT_W) - 1;

  // {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush, hlt, mem_err}
  localparam logic [8:0] MEMV   = 9'b110101100;
  localparam logic [8:0] STALLV = 9'b110010000;
  localparam logic [8:0] FLUSHV = 9'b001010000;
  localparam logic [8:0] HALTV  = 9'b110101010;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_s_reg, ID_t_reg, EX_dst_reg;
  logic ID_use_s, ID_use_t, ID_hlt, EX_use_dst_reg, EX_mem_re, EX_branch_taken;
  logic MEM_mem_access, mem_rdy;
  logic pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
  logic EX_MEM_stall, MEM_WB_flush, hlt, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [8:0] got;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_s_reg(ID_s_reg), .ID_t_reg(ID_t_reg), .ID_use_s(ID_use_s), .ID_use_t(ID_use_t),
    .ID_hlt(ID_hlt), .EX_dst_reg(EX_dst_reg), .EX_use_dst_reg(EX_use_dst_reg),
    .EX_mem_re(EX_mem_re), .EX_branch_taken(EX_branch_taken),
    .MEM_mem_access(MEM_mem_access), .mem_rdy(mem_rdy),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .MEM_WB_flush(MEM_WB_flush), .hlt(hlt), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  assign got = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
                EX_MEM_stall, MEM_WB_flush, hlt, mem_err};

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: wait cycles elapsed (0 = no wait pending), drain progress, halt, error, stall count.
  int m_wait = 0, m_drained = 0, m_cnt = 0;
  bit m_drain = 0, m_halt = 0, m_err = 0;

  task automatic cyc(input string tag);
    logic [8:0] e;
    bit lu, ms, nd, nh, ne;
    int nw, ndd, nc;
    nw = m_wait; nd = m_drain; ndd = m_drained; nh = m_halt; ne = m_err;
    lu = EX_mem_re && EX_use_dst_reg && EX_dst_reg != 0 &&
         ((ID_use_s && ID_s_reg == EX_dst_reg) || (ID_use_t && ID_t_reg == EX_dst_reg));
    ms = MEM_mem_access && !mem_rdy;
    e = '0;
    if (rst) begin
      nw = 0; nd = 0; ndd = 0; nh = 0; ne = 0;
    end else if (m_halt) e = HALTV;
    else if (m_wait > 0) begin
      if (mem_rdy) nw = 0;
      else begin
        e = MEMV;
        if (m_wait == MEM_TIMEOUT) begin ne = 1; nh = 1; nw = 0; end
        else nw = m_wait + 1;
      end
    end else if (m_drain) begin
      if (ms) e = MEMV;
      else begin
        e = STALLV;
        ndd = m_drained + 1;
        if (ndd == DRAIN_CYCLES) begin nd = 0; nh = 1; end
      end
    end else if (ms) begin e = MEMV; nw = 1; end
    else if (EX_branch_taken) e = FLUSHV;
    else if (lu) e = STALLV;
    else if (ID_hlt) begin e = STALLV; nd = 1; ndd = 0; end
    if (!rst) e[0] = m_err;
    nc = rst ? 0 : (e[8] && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    @(negedge clk);
    chk({tag, "/ctl"}, 32'(got), 32'(e));
    chk({tag, "/cnt"}, 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk); #1;
    m_wait = nw; m_drain = nd; m_drained = ndd; m_halt = nh; m_err = ne; m_cnt = nc;
  endtask

  task automatic idle();
    rst = 0; ID_s_reg = 0; ID_t_reg = 0; EX_dst_reg = 0; ID_use_s = 0; ID_use_t = 0;
    ID_hlt = 0; EX_use_dst_reg = 0; EX_mem_re = 0; EX_branch_taken = 0;
    MEM_mem_access = 0; mem_rdy = 1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc("rst"); rst = 0;
  endtask

  task automatic set_lu(input logic [4:0] dst);
    EX_mem_re = 1; EX_use_dst_reg = 1; EX_dst_reg = dst; ID_use_t = 1; ID_t_reg = dst;
  endtask

  int burst;

  initial begin
    idle(); rst = 1;
    @(posedge clk); #1;
    cyc("rst0");
    idle(); cyc("idle");
    // Load-use on r5, then the r0 variant must not stall.
    do_reset(); set_lu(5'd5); cyc("lu"); idle(); cyc("lu_after");
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    set_lu(5'd0); cyc("lu_r0"); idle();
    chk("lu_r0_cnt", 32'(stall_cnt), 32'd1);
    // Branch beats load-use and HLT.
    do_reset(); set_lu(5'd7); ID_hlt = 1; EX_branch_taken = 1; cyc("br"); idle(); cyc("br_after");
    // Four-cycle memory wait.
    do_reset(); MEM_mem_access = 1; mem_rdy = 0;
    repeat (4) cyc("mw");
    mem_rdy = 1; cyc("mw_rdy"); idle(); cyc("mw_after");
    chk("mw_cnt", 32'(stall_cnt), 32'd4);
    // Timeout: first stall cycle plus MEM_TIMEOUT wait cycles lands in HALT.
    do_reset(); MEM_mem_access = 1; mem_rdy = 0;
    repeat (MEM_TIMEOUT + 1) cyc("to");
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_hlt", 32'(hlt), 32'd1);
    idle(); repeat (3) cyc("to_hold");
    // Reset out of HALT.
    do_reset();
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    // HLT drain, with a 2-cycle memory wait in the middle.
    ID_hlt = 1; cyc("hlt"); idle(); cyc("dr1");
    MEM_mem_access = 1; mem_rdy = 0; repeat (2) cyc("dr_mw");
    idle(); cyc("dr2");
    chk("dr_not_halted", 32'(hlt), 32'd0);
    cyc("dr3");
    chk("dr_halted", 32'(hlt), 32'd1);
    // Reset during a memory wait.
    do_reset(); MEM_mem_access = 1; mem_rdy = 0; repeat (3) cyc("mw2");
    do_reset(); cyc("mw2_after");

    // Randomized traffic with bursts of memory wait and occasional resets.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      idle();
      ID_s_reg = 5'($urandom_range(0, 3)); ID_t_reg = 5'($urandom_range(0, 3));
      EX_dst_reg = 5'($urandom_range(0, 3));
      ID_use_s = 1'($urandom); ID_use_t = 1'($urandom);
      EX_use_dst_reg = 1'($urandom); EX_mem_re = 1'($urandom);
      EX_branch_taken = ($urandom_range(0, 5) == 0);
      ID_hlt = ($urandom_range(0, 15) == 0);
      if (burst == 0 && $urandom_range(0, 10) == 0) burst = $urandom_range(1, 20);
      if (burst > 0) begin
        MEM_mem_access = 1; mem_rdy = 0; burst--;
      end else begin
        MEM_mem_access = 1'($urandom); mem_rdy = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 60) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      cyc("rnd");
    end

    // Long halt saturates the stall counter.
    do_reset(); ID_hlt = 1; cyc("sat_hlt"); idle();
    repeat (CMAX + 20) cyc("sat");
    chk("sat_cnt", 32'(stall_cnt), 32'(CMAX));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline controller that generates the stall, flush and halt controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards and taken branches.
- Sequences multi-cycle data/sprite memory waits, with a timeout.
- Drains the pipeline on a decoded HLT, then parks the core in halt.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_err is set and the core halts.
DRAIN_CYCLES, 3, cycles spent in DRAIN after an HLT leaves ID (EX, MEM, WB retire).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock; reset is synchronous and active-high
ID_s_reg  in  5  ID source register s
ID_t_reg  in  5  ID source register t
ID_use_s  in  1  ID instruction reads s
ID_use_t  in  1  ID instruction reads t
ID_hlt  in  1  HLT decoded in ID
EX_dst_reg  in  5  EX destination register
EX_use_dst_reg  in  1  EX writes a register
EX_mem_re  in  1  EX is a load (data or sprite memory)
EX_branch_taken  in  1  branch resolved taken in EX
MEM_mem_access  in  1  MEM stage holds a memory read/write
mem_rdy  in  1  memory completes the MEM-stage access this cycle
pc_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  zero IF/ID
ID_EX_stall  out  1  hold ID/EX
ID_EX_flush  out  1  zero ID/EX (bubble)
EX_MEM_stall  out  1  hold EX/MEM
MEM_WB_flush  out  1  zero MEM/WB
hlt  out  1  core halted (drives the pipeline-register hlt inputs)
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALT. State, counters and mem_err are registered. Control outputs are combinational from state and current inputs (zero-latency hazard response).
- rst=1 (at any time, including mid-wait or mid-drain): on the next edge, state=RUN, wait_cnt=0, drain_cnt=0, mem_err=0, stall_cnt=0. While rst=1, every control output, hlt and mem_err read 0.
- Load-use hit: EX_mem_re & EX_use_dst_reg & EX_dst_reg!=0 & ((ID_use_s & ID_s_reg==EX_dst_reg) | (ID_use_t & ID_t_reg==EX_dst_reg)). Register 0 never hazards.
- Priority in RUN (first match wins):
  1. MEM_mem_access & !mem_rdy: all of pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_flush =1. Next state MEM_WAIT, wait_cnt=1.
  2. EX_branch_taken: IF_ID_flush=1 and ID_EX_flush=1; pc_stall=0 (PC loads target). A concurrent ID_hlt or load-use is squashed.
  3. Load-use hit: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1. Lasts one cycle.
  4. ID_hlt: same outputs as load-use. Next state DRAIN, drain_cnt=0.
  5. Otherwise all outputs 0.
- MEM_WAIT:
  - Outputs as RUN item 1 while mem_rdy=0.
  - mem_rdy=1: outputs all 0 (the pipeline advances that edge) and next state RUN.
  - wait_cnt increments each cycle. If wait_cnt==MEM_TIMEOUT with mem_rdy=0: mem_err<=1, next state HALT.
- DRAIN:
  - pc_stall=1, IF_ID_stall=1, ID_EX_flush=1. Branch and load-use inputs are ignored.
  - A MEM-stage wait in DRAIN stalls per RUN item 1 (EX_MEM_stall and MEM_WB_flush also asserted) and does not advance drain_cnt.
  - Otherwise drain_cnt increments. At drain_cnt==DRAIN_CYCLES-1, next state HALT.
- HALT: hlt=1, pc_stall=1, IF_ID_stall=1, ID_EX_stall=1, EX_MEM_stall=1. Exit only via rst.
- stall_cnt: +1 on every edge where pc_stall=1, saturating at all-ones, no wrap.
- mem_err stays set until rst.

Test Plan:
- Load-use: EX_mem_re=1, EX_use_dst_reg=1, EX_dst_reg=5, ID_use_t=1, ID_t_reg=5 -> one cycle of pc_stall=1, IF_ID_stall=1, ID_EX_flush=1, then all 0; stall_cnt=1. Repeat with EX_dst_reg=0 -> no stall.
- Branch vs hazard: EX_branch_taken=1 with a load-use hit and ID_hlt=1 in the same cycle -> IF_ID_flush=1, ID_EX_flush=1, pc_stall=0; state stays RUN.
- Memory wait: MEM_mem_access=1, mem_rdy=0 for 4 cycles, then 1 -> 4 cycles of all stalls plus MEM_WB_flush, release on the mem_rdy cycle; stall_cnt=4.
- Timeout: mem_rdy held 0 with MEM_TIMEOUT=16 -> mem_err=1 and hlt=1 after 16 wait cycles; both stay set until rst.
- Halt drain: ID_hlt=1 in RUN -> 1 cycle stall, DRAIN for 3 cycles, then hlt=1 permanently. A memory wait inserted mid-drain extends the drain by the wait length.
- Reset mid-operation: rst=1 during MEM_WAIT, then rst=1 in HALT -> next cycle all outputs 0, stall_cnt=0, mem_err=0, state RUN.
